// File: rtl/ic_bvsge_bvlshr_checker_pkg.sv
// Shared types and helpers for the (x >> s) >=s t Skolem witness checker.
package ic_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEF = 4;

  // Largest positive two's-complement value of width w, zero-extended to 32 bits.
  function automatic logic [31:0] max_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ic_bvsge_bvlshr_checker_if.sv
// Operand/result handshake bundle of the witness checker, plus counter clear and readout.
interface ic_bvsge_bvlshr_checker_if
  import ic_checker_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  s;
  logic [W-1:0]  t;
  logic          out_valid;
  logic          out_ready;
  logic          res_sat;
  logic          res_ic;
  logic          res_viol;
  logic [CW-1:0] viol_cnt;
  logic          cnt_clr;

  modport master (
    output in_valid, x, s, t, out_ready, cnt_clr,
    input  in_ready, out_valid, res_sat, res_ic, res_viol, viol_cnt
  );

  modport slave (
    input  in_valid, x, s, t, out_ready, cnt_clr,
    output in_ready, out_valid, res_sat, res_ic, res_viol, viol_cnt
  );
endinterface

// File: rtl/ic_bvsge_bvlshr_checker_cmp.sv
// Combinational signed comparison a >=s b.
module ic_sge_cmp #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic                o_ge
);
  assign o_ge = (i_a >= i_b);
endmodule

// File: rtl/ic_bvsge_bvlshr_checker.sv
// Bit-serial checker: shifts x right by s, compares against t, and flags
// witnesses that fail the constraint while the invertibility condition holds.
module ic_bvsge_bvlshr_checker
  import ic_checker_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 8
) (
  input logic                      clk,
  input logic                      rst,
  ic_bvsge_bvlshr_checker_if.slave bus
);
  localparam int            CNTW    = $clog2(W + 1);
  localparam logic [W-1:0]  MAXP    = W'(max_pos(W));
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          r_state, w_next;
  logic [W-1:0]    r_lhs, r_mask, r_s, r_t;
  logic [CNTW-1:0] r_cnt;
  logic            r_sat, r_ic, r_viol;
  logic [CW-1:0]   r_viol_cnt;
  logic            w_accept, w_done_hs, w_sat, w_ic;
  logic [W-1:0]    w_m;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_done_hs = (r_state == DONE) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = (bus.s != '0) ? SHIFT : CMP;
      SHIFT:   if (r_cnt == CNTW'(1)) w_next = CMP;
      CMP:     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  // Shift amounts of W or more saturate at W steps, leaving lhs and mask all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lhs  <= '0;
      r_mask <= '0;
      r_s    <= '0;
      r_t    <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_ic   <= 1'b0;
      r_viol <= 1'b0;
    end else if (w_accept) begin
      r_lhs  <= bus.x;
      r_mask <= '1;
      r_s    <= bus.s;
      r_t    <= bus.t;
      r_cnt  <= ({1'b0, bus.s} >= (W + 1)'(W)) ? CNTW'(W) : CNTW'(bus.s);
    end else if (r_state == SHIFT) begin
      r_lhs  <= r_lhs >> 1;
      r_mask <= r_mask >> 1;
      r_cnt  <= r_cnt - CNTW'(1);
    end else if (r_state == CMP) begin
      r_sat  <= w_sat;
      r_ic   <= w_ic;
      r_viol <= w_ic & ~w_sat;
    end
  end

  // A zero shift uses the largest positive value rather than the all-ones mask.
  assign w_m = (r_s == '0) ? MAXP : r_mask;

  ic_sge_cmp #(.W(W)) u_sat_cmp (.i_a(r_lhs), .i_b(r_t), .o_ge(w_sat));
  ic_sge_cmp #(.W(W)) u_ic_cmp  (.i_a(w_m),   .i_b(r_t), .o_ge(w_ic));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_viol_cnt <= '0;
    else if (bus.cnt_clr)                             r_viol_cnt <= '0;
    else if (w_done_hs && r_viol && r_viol_cnt != CNT_MAX) r_viol_cnt <= r_viol_cnt + CW'(1);
  end

  assign bus.res_sat  = r_sat;
  assign bus.res_ic   = r_ic;
  assign bus.res_viol = r_viol;
  assign bus.viol_cnt = r_viol_cnt;
endmodule

// File: tb/tb_ic_bvsge_bvlshr_checker.sv
// Scoreboard bench for the witness checker: expected results are queued at accept and compared at out_valid.
module tb_ic_bvsge_bvlshr_checker;
  localparam int W  = 4;
  localparam int CW = 8;

  typedef struct {
    logic sat;
    logic ic;
    logic viol;
    int   lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_cnt;
  exp_t sb[$];

  ic_bvsge_bvlshr_checker_if #(.W(W), .CW(CW)) bus ();

  ic_bvsge_bvlshr_checker #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] s, input logic [W-1:0] t);
    exp_t e;
    int sh;
    logic [W-1:0] lhs, m;
    sh = (int'(s) >= W) ? W : int'(s);
    lhs = x >> sh;
    m = 4'hF >> sh;
    if (s == '0) m = 4'h7;
    e.sat  = ($signed(lhs) >= $signed(t));
    e.ic   = ($signed(t) <= $signed(m));
    e.viol = e.ic & ~e.sat;
    e.lat  = sh + 2;
    return e;
  endfunction

  // One complete transaction; hold = cycles of backpressure in DONE, clr = cnt_clr at the handshake.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] s, input logic [W-1:0] t,
                        input int hold, input logic clr);
    exp_t e;
    int   n;
    int   lat;
    logic r_sat0, r_ic0, r_viol0;
    sb.push_back(model(x, s, t));
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.x = x;
    bus.s = s;
    bus.t = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = ~x;
    bus.s = s + 4'd3;
    bus.t = ~t;
    lat = 1;
    while (!bus.out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check_eq("latency", 32'(lat), 32'(e.lat));
    check_eq("res_sat", 32'(bus.res_sat), 32'(e.sat));
    check_eq("res_ic", 32'(bus.res_ic), 32'(e.ic));
    check_eq("res_viol", 32'(bus.res_viol), 32'(e.viol));
    r_sat0 = bus.res_sat;
    r_ic0 = bus.res_ic;
    r_viol0 = bus.res_viol;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("hold_res", 32'({bus.res_sat, bus.res_ic, bus.res_viol}), 32'({r_sat0, r_ic0, r_viol0}));
    end
    bus.in_valid  = 1'b0;
    bus.cnt_clr   = clr;
    bus.out_ready = 1'b1;
    @(posedge clk);
    if (clr) exp_cnt = 0;
    else if (e.viol && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    check_eq("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("viol_cnt", 32'(bus.viol_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.s = '0;
    bus.t = '0;
    bus.out_ready = 1'b0;
    bus.cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_res", 32'({bus.res_sat, bus.res_ic, bus.res_viol}), 32'd0);
    check_eq("rst_viol_cnt", 32'(bus.viol_cnt), 32'd0);
    rst = 1'b0;

    run_op(4'b1100, 4'd2, 4'b0011, 0, 1'b0);
    run_op(4'b0111, 4'd0, 4'b1000, 0, 1'b0);
    run_op(4'b1111, 4'b0101, 4'b0001, 0, 1'b0);
    run_op(4'b0000, 4'd1, 4'b0010, 0, 1'b0);
    run_op(4'b1000, 4'd4, 4'b1111, 0, 1'b0);
    run_op(4'b0110, 4'd3, 4'b1000, 0, 1'b0);

    for (int i = 0; i < 299; i++) run_op(4'b0000, 4'd1, 4'b0010, 0, 1'b0);
    check_eq("viol_cnt_saturated", 32'(bus.viol_cnt), 32'd255);
    run_op(4'b0000, 4'd1, 4'b0010, 0, 1'b1);
    check_eq("viol_cnt_cleared", 32'(bus.viol_cnt), 32'd0);

    run_op(4'b0000, 4'd1, 4'b0010, 3, 1'b0);
    run_op(4'b1100, 4'd2, 4'b0011, 3, 1'b0);

    // Abandon an operation in its second shift cycle.
    @(negedge clk);
    bus.x = 4'b1010;
    bus.s = 4'd3;
    bus.t = 4'b0001;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("arst_viol_cnt", 32'(bus.viol_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("arst_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_op(4'b0100, 4'd1, 4'b0011, 0, 1'b0);
    run_op(4'b1110, 4'd0, 4'b1111, 0, 1'b0);

    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
